// File: rtl/arm_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : arm_imm_encoder
// Purpose  : Iterative encoder for ARM data-processing rotated immediates.
//            Given a 32-bit constant it finds the smallest rotate field k
//            and an 8-bit immediate such that immediate ROR (2*k) == value.
//            One rotate candidate is evaluated per clock.
// Ports    : clk        - clock, rising edge
//            reset_n    - synchronous active-low reset
//            start      - request pulse, accepted in IDLE or DONE
//            value      - constant to encode (captured on accepted start)
//            carry_in   - current C flag (captured on accepted start)
//            busy       - high while searching
//            done       - one-cycle pulse when the result registers update
//            valid      - 1 = encoding found
//            immediate  - immed_8 field
//            rotate_imm - rotate field
//            carry_out  - shifter carry of the decoded operand
//            inverted   - 1 = encoding is of ~value (MVN form)
// Options  : ARM_IMM_INVERT_EN - after a full miss, retry the search on
//            ~value and flag a hit through 'inverted'. Without it,
//            'inverted' is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module arm_imm_encoder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        carry_in,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [7:0]  immediate,
    output logic [3:0]  rotate_imm,
    output logic        carry_out,
    output logic        inverted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] c_K_LAST = 4'd15;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_target, w_target_nxt;
    logic        r_carry_in, w_carry_in_nxt;
    logic [3:0]  r_k, w_k_nxt;
    logic        r_valid, w_valid_nxt;
    logic [7:0]  r_imm, w_imm_nxt;
    logic [3:0]  r_rot, w_rot_nxt;
    logic        r_carry_out, w_carry_out_nxt;
    logic        w_inv_nxt;
    logic        w_retry;
    logic        w_phase_set;

    logic [5:0]  w_sh;
    logic [31:0] w_cand;
    logic        w_hit;
    logic        w_hit_carry;

    // Candidate = target ROL (2*k). A shift by 32 yields zero, so k==0
    // degenerates to the target itself.
    assign w_sh        = {1'b0, r_k, 1'b0};
    assign w_cand      = (r_target << w_sh) | (r_target >> (6'd32 - w_sh));
    assign w_hit       = (w_cand[31:8] == 24'd0);
    // The decoded operand (cand ROR 2k) is exactly the current target.
    assign w_hit_carry = (r_k == 4'd0) ? r_carry_in : r_target[31];

`ifdef ARM_IMM_INVERT_EN
    logic r_phase, w_phase_nxt;
    logic r_inverted;
    assign w_retry  = ~r_phase;
    assign inverted = r_inverted;
`else
    assign w_retry  = 1'b0;
    assign inverted = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_target_nxt    = r_target;
        w_carry_in_nxt  = r_carry_in;
        w_k_nxt         = r_k;
        w_valid_nxt     = r_valid;
        w_imm_nxt       = r_imm;
        w_rot_nxt       = r_rot;
        w_carry_out_nxt = r_carry_out;
        w_inv_nxt       = inverted;
        w_phase_set     = 1'b0;
`ifdef ARM_IMM_INVERT_EN
        w_phase_nxt     = r_phase;
`endif
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (start) begin
                    w_state_nxt    = ST_SEARCH;
                    w_target_nxt   = value;
                    w_carry_in_nxt = carry_in;
                    w_k_nxt        = 4'd0;
`ifdef ARM_IMM_INVERT_EN
                    w_phase_nxt    = 1'b0;
`endif
                end
            end
            ST_SEARCH: begin
                if (w_hit) begin
                    w_state_nxt     = ST_DONE;
                    w_valid_nxt     = 1'b1;
                    w_imm_nxt       = w_cand[7:0];
                    w_rot_nxt       = r_k;
                    w_carry_out_nxt = w_hit_carry;
`ifdef ARM_IMM_INVERT_EN
                    w_inv_nxt       = r_phase;
`endif
                end else if (r_k == c_K_LAST) begin
                    if (w_retry) begin
                        // Second pass over the complemented constant.
                        w_target_nxt = ~r_target;
                        w_k_nxt      = 4'd0;
                        w_phase_set  = 1'b1;
                    end else begin
                        w_state_nxt     = ST_DONE;
                        w_valid_nxt     = 1'b0;
                        w_imm_nxt       = 8'd0;
                        w_rot_nxt       = 4'd0;
                        w_carry_out_nxt = 1'b0;
                        w_inv_nxt       = 1'b0;
                    end
                end else begin
                    w_k_nxt = r_k + 4'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
`ifdef ARM_IMM_INVERT_EN
        if (w_phase_set) begin
            w_phase_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_target    <= 32'd0;
            r_carry_in  <= 1'b0;
            r_k         <= 4'd0;
            r_valid     <= 1'b0;
            r_imm       <= 8'd0;
            r_rot       <= 4'd0;
            r_carry_out <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_target    <= w_target_nxt;
            r_carry_in  <= w_carry_in_nxt;
            r_k         <= w_k_nxt;
            r_valid     <= w_valid_nxt;
            r_imm       <= w_imm_nxt;
            r_rot       <= w_rot_nxt;
            r_carry_out <= w_carry_out_nxt;
        end
    end

`ifdef ARM_IMM_INVERT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_phase    <= 1'b0;
            r_inverted <= 1'b0;
        end else begin
            r_phase    <= w_phase_nxt;
            r_inverted <= w_inv_nxt;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_inv_nxt | w_phase_set;
`endif

    assign busy       = (r_state == ST_SEARCH);
    assign done       = (r_state == ST_DONE);
    assign valid      = r_valid;
    assign immediate  = r_imm;
    assign rotate_imm = r_rot;
    assign carry_out  = r_carry_out;

endmodule
`default_nettype wire

// File: tb/tb_arm_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_imm_encoder
// Purpose  : Scoreboard bench for arm_imm_encoder. Directed requests push
//            their hand-computed result and due cycle into a queue; a
//            monitor pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_arm_imm_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value = 32'd0;
    logic        carry_in = 1'b0;
    logic        busy, done, valid, carry_out, inverted;
    logic [7:0]  immediate;
    logic [3:0]  rotate_imm;

    arm_imm_encoder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .value      (value),
        .carry_in   (carry_in),
        .busy       (busy),
        .done       (done),
        .valid      (valid),
        .immediate  (immediate),
        .rotate_imm (rotate_imm),
        .carry_out  (carry_out),
        .inverted   (inverted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] val;
        logic        v;
        logic [7:0]  imm;
        logic [3:0]  rot;
        logic        cy;
        logic        inv;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;

`ifdef ARM_IMM_INVERT_EN
    localparam int c_LAT_MISS = 32;
`else
    localparam int c_LAT_MISS = 16;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int sh);
        int s;
        s = sh % 32;
        if (s == 0) return x;
        return (x >> s) | (x << (32 - s));
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                m_e = sb.pop_front();
                check("valid",      {31'd0, valid},      {31'd0, m_e.v});
                check("immediate",  {24'd0, immediate},  {24'd0, m_e.imm});
                check("rotate_imm", {28'd0, rotate_imm}, {28'd0, m_e.rot});
                check("carry_out",  {31'd0, carry_out},  {31'd0, m_e.cy});
                check("inverted",   {31'd0, inverted},   {31'd0, m_e.inv});
                check("latency",    cyc,                 m_e.due);
                check("busy_in_done", {31'd0, busy},     32'd0);
                if (m_e.v) begin
                    if (m_e.inv)
                        check("decode_inv", ~ror32({24'd0, immediate}, 2 * int'(rotate_imm)), m_e.val);
                    else
                        check("decode", ror32({24'd0, immediate}, 2 * int'(rotate_imm)), m_e.val);
                end
            end
        end
    end

    // Call at a negedge; returns 1ns after the accepting edge.
    task automatic issue(input logic [31:0] v, input logic c, input logic ev,
                         input logic [7:0] ei, input logic [3:0] er,
                         input logic ecy, input logic einv, input int lat);
        exp_t e;
        value    = v;
        carry_in = c;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        e.val = v; e.v = ev; e.imm = ei; e.rot = er;
        e.cy = ecy; e.inv = einv; e.due = cyc + lat;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input logic [31:0] v, input logic c, input logic ev,
                       input logic [7:0] ei, input logic [3:0] er,
                       input logic ecy, input logic einv, input int lat);
        @(negedge clk);
        issue(v, c, ev, ei, er, ecy, einv, lat);
        wait_done(40);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"},      {31'd0, busy},       32'd0);
        check({tag, "_done"},      {31'd0, done},       32'd0);
        check({tag, "_valid"},     {31'd0, valid},      32'd0);
        check({tag, "_immediate"}, {24'd0, immediate},  32'd0);
        check({tag, "_rotate"},    {28'd0, rotate_imm}, 32'd0);
        check({tag, "_carry"},     {31'd0, carry_out},  32'd0);
        check({tag, "_inverted"},  {31'd0, inverted},   32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        reset_n = 1'b1;

        //   value         cin  v  imm    rot    cy  inv lat
        run(32'h0000000A, 1'b1, 1, 8'h0A, 4'd0,  1,  0,  1);
        run(32'hA0000000, 1'b0, 1, 8'h0A, 4'd2,  1,  0,  3);
        run(32'h000003FC, 1'b1, 1, 8'hFF, 4'd15, 0,  0,  16);
        run(32'h00000101, 1'b1, 0, 8'h00, 4'd0,  0,  0,  c_LAT_MISS);
`ifdef ARM_IMM_INVERT_EN
        run(32'hFFFFFF00, 1'b1, 1, 8'hFF, 4'd0,  1,  1,  17);
`else
        run(32'hFFFFFF00, 1'b1, 0, 8'h00, 4'd0,  0,  0,  16);
`endif
        run(32'h00000000, 1'b0, 1, 8'h00, 4'd0,  0,  0,  1);
        run(32'h00000000, 1'b1, 1, 8'h00, 4'd0,  1,  0,  1);
        run(32'h000003F0, 1'b1, 1, 8'h3F, 4'd14, 0,  0,  15);
        run(32'h80000001, 1'b0, 1, 8'h06, 4'd1,  1,  0,  2);

        // Back-to-back: new start issued during the DONE cycle.
        run(32'hA0000000, 1'b1, 1, 8'h0A, 4'd2,  1,  0,  3);
        issue(32'hFF000000, 1'b0, 1, 8'hFF, 4'd4, 1, 0, 5);
        wait_done(40);

        // Start during SEARCH must be ignored.
        @(negedge clk);
        issue(32'h000003FC, 1'b0, 1, 8'hFF, 4'd15, 0, 0, 16);
        repeat (4) @(negedge clk);
        value = 32'h00000005;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_ignored_start", {31'd0, busy}, 32'd1);
        wait_done(40);

        // Reset mid-search: outputs cleared, request discarded, no done.
        @(negedge clk);
        issue(32'h00000101, 1'b1, 0, 8'h00, 4'd0, 0, 0, c_LAT_MISS);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        void'(sb.pop_back());
        check_cleared("midreset");
        repeat (40) @(negedge clk);
        check("idle_after_reset", {31'd0, busy}, 32'd0);

        run(32'hA0000000, 1'b0, 1, 8'h0A, 4'd2, 1, 0, 3);

        @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
